// File: rtl/mdio_pkg.sv
// Shared definitions for the clause-22 MDIO master: FSM states, frame field
// constants and slot boundaries within the 65-slot frame.
package mdio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        HEADER,
        TURNAROUND,
        DATA,
        GAP
    } mdio_state_e;

    localparam logic [1:0] ST       = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] TA_WRITE = 2'b10;

    localparam int PREAMBLE_LEN = 32;
    localparam int FRAME_SLOTS  = 65;

    // Last slot index of each frame section.
    localparam logic [6:0] PREAMBLE_END = 7'(PREAMBLE_LEN - 1);
    localparam logic [6:0] HEADER_END   = 7'd45;
    localparam logic [6:0] TA_END       = 7'd47;
    localparam logic [6:0] DATA_END     = 7'd63;
    localparam logic [6:0] GAP_SLOT     = 7'(FRAME_SLOTS - 1);

endpackage

// File: rtl/mdio_tick_gen.sv
// MDC divider: counts the 2*CLK_DIV cycles of one bit slot and flags the
// cycle before MDC rises, the last cycle of the slot and the one before it.
module mdio_tick_gen #(
    parameter int CLK_DIV = 50
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic rise_o,
    output logic sample_o,
    output logic pre_last_o
);

    localparam int CW = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] RISE_AT = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] LAST_AT = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] PRE_AT  = CW'(2 * CLK_DIV - 2);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i || !en_i || cnt_q == LAST_AT) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign rise_o     = en_i && (cnt_q == RISE_AT);
    assign sample_o   = en_i && (cnt_q == LAST_AT);
    assign pre_last_o = en_i && (cnt_q == PRE_AT);

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: serialises one read or write frame per accepted
// request and returns a single-cycle response 130*CLK_DIV cycles later.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int CLK_DIV = 50
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    // Request handshake: a request is taken on any cycle with valid & ready;
    // ready is high only while idle, and valid may be held across responses.
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [4:0]  req_phy_addr_i,
    input  logic [4:0]  req_reg_addr_i,
    input  logic [15:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        mdc_o,
    output logic        mdio_o,
    output logic        mdio_oe_o,
    input  logic        mdio_i,
    output mdio_state_e state_o
);

    mdio_state_e state_q, state_d;
    logic [6:0]  slot_q, slot_nxt;
    logic        wr_q;
    logic [4:0]  phy_q, reg_q;
    logic [15:0] wdata_q, rx_q;
    logic        err_q;
    logic        sync1_q, sync2_q;
    logic        rise, sample, pre_last;
    logic        hs, run, done, oe_nxt;
    logic [63:0] frame;

    assign req_ready_o = (state_q == IDLE);
    assign hs          = req_valid_i && req_ready_o;
    assign run         = (state_q != IDLE);
    assign done        = (state_q == GAP) && pre_last;
    assign state_o     = state_q;

    mdio_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (run),
        .clr_i      (done),
        .rise_o     (rise),
        .sample_o   (sample),
        .pre_last_o (pre_last)
    );

    // Read frames carry ones in TA/DATA; the pad is released there anyway.
    assign frame = {{PREAMBLE_LEN{1'b1}}, ST, (wr_q ? OP_WRITE : OP_READ), phy_q, reg_q,
                    (wr_q ? TA_WRITE : 2'b11), (wr_q ? wdata_q : 16'hFFFF)};
    assign slot_nxt = slot_q + 7'd1;
    assign oe_nxt   = wr_q ? (slot_nxt <= DATA_END) : (slot_nxt <= HEADER_END);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (req_valid_i) state_d = PREAMBLE;
            PREAMBLE:   if (sample && slot_q == PREAMBLE_END) state_d = HEADER;
            HEADER:     if (sample && slot_q == HEADER_END) state_d = TURNAROUND;
            TURNAROUND: if (sample && slot_q == TA_END) state_d = DATA;
            DATA:       if (sample && slot_q == DATA_END) state_d = GAP;
            GAP:        if (pre_last) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q  <= '0;
            wr_q    <= 1'b0;
            phy_q   <= '0;
            reg_q   <= '0;
            wdata_q <= '0;
        end else if (hs) begin
            slot_q  <= '0;
            wr_q    <= req_write_i;
            phy_q   <= req_phy_addr_i;
            reg_q   <= req_reg_addr_i;
            wdata_q <= req_wdata_i;
        end else if (done) begin
            slot_q  <= '0;
        end else if (sample) begin
            slot_q  <= slot_nxt;
        end
    end

    // Pad outputs change only at slot starts; MDC rises half a slot later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mdc_o     <= 1'b0;
            mdio_o    <= 1'b1;
            mdio_oe_o <= 1'b0;
        end else if (hs) begin
            mdc_o     <= 1'b0;
            mdio_o    <= 1'b1;
            mdio_oe_o <= 1'b1;
        end else if (done) begin
            mdc_o     <= 1'b0;
            mdio_o    <= 1'b1;
            mdio_oe_o <= 1'b0;
        end else if (sample) begin
            mdc_o     <= 1'b0;
            mdio_o    <= (slot_nxt == GAP_SLOT) ? 1'b1 : frame[~slot_nxt[5:0]];
            mdio_oe_o <= oe_nxt;
        end else if (rise) begin
            mdc_o     <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            rx_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= mdio_i;
            sync2_q <= sync1_q;
            if (sample && slot_q == TA_END) begin
                err_q <= sync2_q;
            end
            if (sample && state_q == DATA) begin
                rx_q <= {rx_q[14:0], sync2_q};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            rsp_valid_o <= done;
            if (done) begin
                rsp_rdata_o <= wr_q ? 16'h0000 : rx_q;
                rsp_err_o   <= wr_q ? 1'b0 : err_q;
            end
        end
    end

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master at CLK_DIV=4: table of frames with a PHY model,
// plus back-to-back, mid-frame reset and post-handshake input change cases.
module tb_mdio_master;
    import mdio_pkg::*;

    localparam int CLK_DIV   = 4;
    localparam int FRAME_CYC = 130 * CLK_DIV;
    localparam logic [64:0] OE_WR = {{64{1'b1}}, 1'b0};
    localparam logic [64:0] OE_RD = {{46{1'b1}}, {19{1'b0}}};

    typedef struct {
        logic        write;
        logic [4:0]  phy;
        logic [4:0]  regad;
        logic [15:0] wdata;
        logic        phy_present;
        logic [15:0] phy_data;
        logic        corrupt;
        logic [63:0] exp_frame;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_write;
    logic [4:0]  req_phy, req_reg;
    logic [15:0] req_wdata;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_rdata;
    logic        mdc, mdio_out, mdio_oe, mdio_in;
    mdio_state_e state;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    logic [15:0] exp_q[$];
    vec_t vecs[6];

    mdio_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_write_i    (req_write),
        .req_phy_addr_i (req_phy),
        .req_reg_addr_i (req_reg),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_err_o      (rsp_err),
        .mdc_o          (mdc),
        .mdio_o         (mdio_out),
        .mdio_oe_o      (mdio_oe),
        .mdio_i         (mdio_in),
        .state_o        (state)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic phy_bit(input vec_t v, input int slot);
        if (!v.phy_present) return 1'b1;
        if (slot == 47) return 1'b0;
        if (slot >= 48 && slot <= 63) return v.phy_data[63 - slot];
        return 1'b1;
    endfunction

    task automatic wait_rsp(input int from, output int lat);
        lat = -1;
        for (int i = 0; i < FRAME_CYC + 20; i++) begin
            if (rsp_valid) begin
                lat = cyc - from;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Driver + monitor: issue one request, act as PHY, capture every slot on MDC rise
    task automatic run_txn(input vec_t v, input string tag);
        logic [64:0] cap_bits, cap_oe;
        logic [15:0] exp_d;
        logic        prev_mdc, got;
        int          rises, hs_cyc, lat;
        exp_q.push_back(v.exp_rdata);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = v.write;
        req_phy   = v.phy;
        req_reg   = v.regad;
        req_wdata = v.wdata;
        hs_cyc = cyc;
        check({tag, "_ready"}, req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        if (v.corrupt) begin
            req_wdata = 16'hFFFF;
            req_phy   = ~v.phy;
            req_reg   = ~v.regad;
            req_write = ~v.write;
        end
        check({tag, "_busy"}, req_ready, 1'b0);
        cap_bits = '0;
        cap_oe   = '0;
        rises    = 0;
        prev_mdc = 1'b0;
        got      = 1'b0;
        lat      = -1;
        for (int i = 0; i < FRAME_CYC + 20 && !got; i++) begin
            if (i > 0) @(negedge clk);
            if (mdc && !prev_mdc) begin
                cap_bits = {cap_bits[63:0], mdio_out};
                cap_oe   = {cap_oe[63:0], mdio_oe};
                rises++;
            end
            if (!mdc && prev_mdc) mdio_in = phy_bit(v, rises);
            prev_mdc = mdc;
            if (rsp_valid) begin
                got = 1'b1;
                lat = cyc - hs_cyc;
            end
        end
        mdio_in = 1'b1;
        exp_d = exp_q.pop_front();
        if (!got) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: no rsp_valid within %0d cycles", tag, FRAME_CYC + 20);
        end else begin
            check({tag, "_latency"}, lat, FRAME_CYC);
            check({tag, "_rdata"}, rsp_rdata, exp_d);
            check({tag, "_err"}, rsp_err, v.exp_err);
            check({tag, "_slots"}, rises, FRAME_SLOTS);
            check({tag, "_oe"}, cap_oe, v.write ? OE_WR : OE_RD);
            if (v.write) check({tag, "_frame"}, cap_bits[64:1], v.exp_frame);
            else         check({tag, "_header"}, cap_bits[64:19], v.exp_frame[63:18]);
            check({tag, "_idle_mdc"}, {mdc, mdio_oe}, 2'b00);
            @(negedge clk);
            check({tag, "_pulse"}, rsp_valid, 1'b0);
            check({tag, "_hold"}, rsp_rdata, exp_d);
        end
    endtask

    initial begin
        int lat, hs1, hs2, rises, stray;
        logic prev;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_phy   = '0;
        req_reg   = '0;
        req_wdata = '0;
        mdio_in   = 1'b1;
        rst_n     = 1'b0;

        vecs[0] = '{1'b1, 5'd1, 5'd0, 16'h1140, 1'b0, 16'h0000, 1'b0,
                    {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h1140}, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 5'd3, 5'd2, 16'h0000, 1'b1, 16'h0141, 1'b0,
                    {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd3, 5'd2, 18'h0}, 16'h0141, 1'b0};
        vecs[2] = '{1'b0, 5'h1F, 5'h1F, 16'h0000, 1'b0, 16'h0000, 1'b0,
                    {32'hFFFF_FFFF, 2'b01, 2'b10, 5'h1F, 5'h1F, 18'h0}, 16'hFFFF, 1'b1};
        vecs[3] = '{1'b1, 5'h1F, 5'h1F, 16'hA5C3, 1'b0, 16'h0000, 1'b0,
                    {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h1F, 5'h1F, 2'b10, 16'hA5C3}, 16'h0000, 1'b0};
        vecs[4] = '{1'b0, 5'd0, 5'h15, 16'h0000, 1'b1, 16'h8001, 1'b0,
                    {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd0, 5'h15, 18'h0}, 16'h8001, 1'b0};
        vecs[5] = '{1'b1, 5'd5, 5'd9, 16'h1234, 1'b0, 16'h0000, 1'b1,
                    {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd5, 5'd9, 2'b10, 16'h1234}, 16'h0000, 1'b0};

        // Reset state
        #23;
        check("rst_ready", req_ready, 1'b1);
        check("rst_valid", rsp_valid, 1'b0);
        check("rst_rdata", rsp_rdata, 16'h0);
        check("rst_err", rsp_err, 1'b0);
        check("rst_mdc", mdc, 1'b0);
        check("rst_mdio", mdio_out, 1'b1);
        check("rst_oe", mdio_oe, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 6; k++) run_txn(vecs[k], $sformatf("vec%0d", k));

        // Back-to-back with valid held: second accepted in the first response cycle
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_phy   = 5'd2;
        req_reg   = 5'd4;
        req_wdata = 16'hBEEF;
        hs1 = cyc;
        @(negedge clk);
        req_phy   = 5'd6;
        req_reg   = 5'd7;
        req_wdata = 16'h0F0F;
        wait_rsp(hs1, lat);
        check("b2b_lat1", lat, FRAME_CYC);
        check("b2b_ready_in_rsp", req_ready, 1'b1);
        hs2 = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_second_taken", req_ready, 1'b0);
        wait_rsp(hs2, lat);
        check("b2b_lat2", lat, FRAME_CYC);
        check("b2b_lat_total", cyc - hs1, 2 * FRAME_CYC);
        check("b2b_rdata", rsp_rdata, 16'h0);

        // Reset in the high phase of slot 40 aborts the frame
        run_txn(vecs[4], "pre_abort");
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_phy   = 5'd1;
        req_reg   = 5'd0;
        req_wdata = 16'h1140;
        @(negedge clk);
        req_valid = 1'b0;
        rises = 0;
        prev = 1'b0;
        for (int i = 0; i < FRAME_CYC && rises < 41; i++) begin
            @(negedge clk);
            if (mdc && !prev) rises++;
            prev = mdc;
        end
        check("abort_mdc_before", mdc, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_mdc", mdc, 1'b0);
        check("abort_oe", mdio_oe, 1'b0);
        check("abort_mdio", mdio_out, 1'b1);
        check("abort_ready", req_ready, 1'b1);
        check("abort_rdata", rsp_rdata, 16'h0);
        check("abort_state", state, IDLE);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < FRAME_CYC + 40; i++) begin
            @(negedge clk);
            if (rsp_valid) stray++;
        end
        check("abort_no_rsp", stray, 0);
        run_txn(vecs[0], "post_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mdio_master.md
MDIO_MASTER -- requirements
Module: mdio_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50, giving the MDC half-period in clk_i cycles; legal range 3..255.
REQ-002 SHALL have port clk_i  input  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-004 SHALL have port req_valid_i  input  1  management request valid.
REQ-005 SHALL have port req_ready_o  output  1  block idle, request accepted on valid&ready.
REQ-006 SHALL have port req_write_i  input  1  1 = clause-22 write, 0 = read.
REQ-007 SHALL have port req_phy_addr_i  input  5  PHY address.
REQ-008 SHALL have port req_reg_addr_i  input  5  register address.
REQ-009 SHALL have port req_wdata_i  input  16  write data.
REQ-010 SHALL have port rsp_valid_o  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata_o  output  16  read data; 0 for writes.
REQ-012 SHALL have port rsp_err_o  output  1  read turnaround bit not driven low by the PHY.
REQ-013 SHALL have port mdc_o  output  1  management clock to the PHY.
REQ-014 SHALL have port mdio_o  output  1  MDIO drive value.
REQ-015 SHALL have port mdio_oe_o  output  1  MDIO output enable for the pad tristate.
REQ-016 SHALL have port mdio_i  input  1  MDIO pad input, asynchronous.

Function
REQ-017 SHALL use states IDLE, PREAMBLE, HEADER, TURNAROUND, DATA, GAP.
REQ-018 SHALL assert req_ready_o only in IDLE, and SHALL capture all req_* fields on handshake; later input changes are ignored.
REQ-019 SHALL treat a frame as 65 bit slots of 2*CLK_DIV cycles each, where each slot is CLK_DIV cycles with mdc_o low followed by CLK_DIV cycles with mdc_o high; slot 0 starts the cycle after the handshake.
REQ-020 SHALL use this slot map: 0-31 preamble (1), 32-33 ST=01, 34-35 OP (write 01, read 10), 36-40 PHYAD MSB first, 41-45 REGAD MSB first, 46-47 TA, 48-63 DATA MSB first, 64 GAP.
REQ-021 SHALL update mdio_o/mdio_oe_o only in the first cycle of a slot (mdc_o falling).
REQ-022 For writes, SHALL drive oe=1 in slots 0-63, with TA=10, and SHALL release oe in GAP.
REQ-023 For reads, SHALL drive oe=1 in slots 0-45, and oe=0 from slot 46 through GAP.
REQ-024 SHALL pass mdio_i through a 2-flop synchronizer and sample it in the last cycle of each slot's high phase.
REQ-025 For reads, SHALL set rsp_err_o=1 if the sample in slot 47 is 1; data sampled in slots 48-63 forms rsp_rdata_o regardless of error.
REQ-026 SHALL pulse rsp_valid_o exactly 130*CLK_DIV cycles after the handshake cycle; rsp_rdata_o/rsp_err_o hold until the next response.
REQ-027 SHALL return to IDLE in the rsp_valid_o cycle, so a request may be accepted in that same cycle.
REQ-028 SHALL keep mdc_o low and mdio_oe_o=0 while in IDLE.

Reset
REQ-029 SHALL, on rst_ni low at any time including mid-frame, immediately force: state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, mdc_o=0, mdio_o=1, mdio_oe_o=0, and clear all counters and synchronizer flops.
REQ-030 SHALL produce no rsp_valid_o for a frame aborted by reset.

Structure
REQ-031 SHALL place in shared package mdio_pkg: state enum, ST/OP_READ/OP_WRITE/TA_WRITE constants, PREAMBLE_LEN=32, FRAME_SLOTS=65.
REQ-032 SHALL use sub-module mdio_tick_gen (divider counter emitting fall/sample strobes from CLK_DIV); all other logic is in mdio_master.

Verification (CLK_DIV=4, slot=8 cycles)
REQ-033 Write PHY 1, reg 0, data 0x1140 -> serial 32x1, 01 01 00001 00000 10 0001000101000000; rsp_valid_o at cycle 520; rdata 0x0000; err 0.
REQ-034 Read PHY 3, reg 2, with a PHY model returning 0x0141 -> oe falls at slot 46; rdata 0x0141; err 0.
REQ-035 Read with no PHY, mdio_i pulled high -> err 1; rdata 0xFFFF.
REQ-036 Two requests with req_valid_i held -> second accepted in the same cycle as the first rsp_valid_o; second rsp_valid_o 520 cycles later.
REQ-037 Reset asserted at slot 40 -> mdc_o=0, oe=0 asynchronously; no rsp_valid_o; after release a new write completes normally.
REQ-038 req_wdata_i changed to 0xFFFF one cycle after handshake -> serialized data equals the captured value.
